// File: rtl/mano_mem_ctrl.sv
// Memory responder for the Mano CPU bus with a host load/dump port.
// Holds the CPU in reset while the host owns memory; host start/stop hands it over.
module mano_mem_ctrl #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 12,
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_din,
  input  logic              cpu_we,
  output logic [DWIDTH-1:0] cpu_dout,
  output logic              cpu_rst_n,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [DWIDTH-1:0] h_wdata,
  output logic              h_rvalid,
  output logic [DWIDTH-1:0] h_rdata,
  input  logic              h_start,
  input  logic              h_stop,
  output logic [31:0]       run_cycles
);

  localparam int unsigned IW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned RCW = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DWIDTH-1:0] mem [MEM_SIZE];

  logic              host_acc;
  logic              host_wr;
  logic              host_rd;
  logic              cpu_wr;
  logic              host_in_range;
  logic              cpu_in_range;
  logic [DWIDTH-1:0] host_rd_word;
  logic [DWIDTH-1:0] cpu_rd_word;

  // Addresses beyond MEM_SIZE never alias onto real words.
  assign host_in_range = 64'(h_addr) < 64'(MEM_SIZE);
  assign cpu_in_range  = 64'(cpu_addr) < 64'(MEM_SIZE);

  assign host_acc = (state_q == LOAD) && h_valid && h_ready;
  assign host_wr  = host_acc && h_we && host_in_range;
  assign host_rd  = host_acc && !h_we;
  assign cpu_wr   = (state_q == RUN) && cpu_we && cpu_in_range;

  assign host_rd_word = host_in_range ? mem[h_addr[IW-1:0]] : '0;
  assign cpu_rd_word  = cpu_in_range ? mem[cpu_addr[IW-1:0]] : '0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Next state: start/stop together always toggles ownership
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (h_start) state_d = RUN;
      RUN:     if (h_stop)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Storage is intentionally unreset so programs survive a reset pulse
  always_ff @(posedge clk) begin
    if (host_wr)     mem[h_addr[IW-1:0]]   <= h_wdata;
    else if (cpu_wr) mem[cpu_addr[IW-1:0]] <= cpu_din;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout   <= '0;
      cpu_rst_n  <= 1'b0;
      h_ready    <= 1'b0;
      h_rvalid   <= 1'b0;
      h_rdata    <= '0;
      run_cycles <= '0;
    end else begin
      h_ready   <= (state_d == LOAD);
      cpu_rst_n <= (state_d == RUN);
      h_rvalid  <= host_rd;
      if (host_rd)          h_rdata  <= host_rd_word;
      if (state_q == RUN)   cpu_dout <= cpu_rd_word;
      if (state_q == LOAD && state_d == RUN)
        run_cycles <= '0;
      else if (state_q == RUN && run_cycles != {RCW{1'b1}})
        run_cycles <= run_cycles + RCW'(1);
    end
  end

endmodule

// File: tb/tb_mano_mem_ctrl.sv
// Directed + randomized bench for mano_mem_ctrl against an array reference model.
// A second instance with MEM_SIZE = 16 covers out-of-range host accesses.
module tb_mano_mem_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_we;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rst_n;
  logic          h_valid, h_ready, h_we, h_rvalid, h_start, h_stop;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic [31:0]   run_cycles;

  logic [AW-1:0] s_cpu_addr;
  logic [DW-1:0] s_cpu_din;
  logic          s_cpu_we;
  logic [DW-1:0] s_cpu_dout;
  logic          s_cpu_rst_n;
  logic          s_h_valid, s_h_ready, s_h_we, s_h_rvalid, s_h_start, s_h_stop;
  logic [AW-1:0] s_h_addr;
  logic [DW-1:0] s_h_wdata, s_h_rdata;
  logic [31:0]   s_run_cycles;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] ref_mem [4096];
  logic [31:0]   rc_exp;

  always #5 clk = ~clk;

  mano_mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(4096)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_dout(cpu_dout), .cpu_rst_n(cpu_rst_n),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .h_start(h_start), .h_stop(h_stop), .run_cycles(run_cycles)
  );

  mano_mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(16)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(s_cpu_addr), .cpu_din(s_cpu_din), .cpu_we(s_cpu_we),
    .cpu_dout(s_cpu_dout), .cpu_rst_n(s_cpu_rst_n),
    .h_valid(s_h_valid), .h_ready(s_h_ready), .h_we(s_h_we), .h_addr(s_h_addr),
    .h_wdata(s_h_wdata), .h_rvalid(s_h_rvalid), .h_rdata(s_h_rdata),
    .h_start(s_h_start), .h_stop(s_h_stop), .run_cycles(s_run_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    step();
    h_valid = 1'b0; h_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic hread(input logic [AW-1:0] a);
    h_valid = 1'b1; h_we = 1'b0; h_addr = a;
    step();
    h_valid = 1'b0;
    chk("hread_rvalid", h_rvalid, 1);
    chk("hread_rdata", h_rdata, ref_mem[a]);
    chk("hread_ready", h_ready, 1);
    step();
    chk("hread_rvalid_drop", h_rvalid, 0);
  endtask

  // One RUN cycle: read-first data returns next edge, run counter advances
  task automatic cpu_cycle(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    cpu_addr = a; cpu_we = we; cpu_din = d;
    exp = ref_mem[a];
    step();
    rc_exp++;
    chk("cpu_dout", cpu_dout, exp);
    chk("run_cycles", run_cycles, rc_exp);
    if (we) ref_mem[a] = d;
    cpu_we = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] pa, a, adr, pc, last_a;
    logic [DW-1:0] d, exp, op1, op2, ac, ir, last_d;
    logic          we;

    cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0;
    h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_start = 1'b0; h_stop = 1'b0;
    s_cpu_addr = '0; s_cpu_din = '0; s_cpu_we = 1'b0;
    s_h_valid = 1'b0; s_h_we = 1'b0; s_h_addr = '0; s_h_wdata = '0;
    s_h_start = 1'b0; s_h_stop = 1'b0;
    last_a = 12'h100; last_d = '0;

    #1 reset_n = 1'b0;
    #11;
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_h_ready", h_ready, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_h_rdata", h_rdata, 0);
    chk("rst_run_cycles", run_cycles, 0);

    @(posedge clk); #1 reset_n = 1'b1;
    step();
    chk("load_h_ready", h_ready, 1);
    chk("load_cpu_rst_n", cpu_rst_n, 0);

    hwrite(12'h000, 32'h0000_2004);
    hwrite(12'h001, 32'h0000_7001);
    hwrite(12'h004, 32'h0000_0005);
    hread(12'h004);
    chk("load_cpu_rst_n_hold", cpu_rst_n, 0);

    for (int i = 0; i < 16; i++) hwrite(12'h100 + AW'(i), $urandom);

    // Back-to-back reads every cycle
    pa = 12'h100 + AW'($urandom_range(0, 15));
    h_addr = pa; h_valid = 1'b1; h_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b2b_rvalid", h_rvalid, 1);
      chk("b2b_rdata", h_rdata, ref_mem[pa]);
      pa = 12'h100 + AW'($urandom_range(0, 15));
      h_addr = pa;
    end
    h_valid = 1'b0;
    step();
    chk("b2b_rvalid_drop", h_rvalid, 0);

    // Start with a host write in the same cycle
    cpu_addr = 12'h010;
    h_start = 1'b1; h_valid = 1'b1; h_we = 1'b1; h_addr = 12'h010; h_wdata = 32'h0000_00AA;
    step();
    h_start = 1'b0; h_valid = 1'b0; h_we = 1'b0;
    ref_mem[12'h010] = 32'h0000_00AA;
    rc_exp = 0;
    chk("start_cpu_rst_n", cpu_rst_n, 1);
    chk("start_h_ready", h_ready, 0);
    chk("start_run_cycles", run_cycles, 0);
    chk("start_cpu_dout_held", cpu_dout, 0);
    for (int i = 0; i < 3; i++) cpu_cycle(12'h010, 1'b0, '0);

    cpu_cycle(12'h004, 1'b1, 32'h0000_0009);
    cpu_cycle(12'h004, 1'b0, '0);

    // Random CPU traffic; host requests and stray starts must be ignored
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        a = last_a; we = 1'b1; d = last_d;
      end else begin
        a = 12'h100 + AW'($urandom_range(0, 15));
        we = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      if (we) begin last_a = a; last_d = d; end
      h_valid = 1'b1; h_we = 1'($urandom_range(0, 1));
      h_addr = 12'h100 + AW'($urandom_range(0, 15)); h_wdata = $urandom;
      h_start = 1'($urandom_range(0, 1));
      cpu_cycle(a, we, d);
      chk("run_h_ready", h_ready, 0);
      chk("run_h_rvalid", h_rvalid, 0);
      chk("run_cpu_rst_n", cpu_rst_n, 1);
    end
    h_valid = 1'b0; h_we = 1'b0; h_start = 1'b0;

    // Stop with a CPU write on the same edge
    d = $urandom;
    exp = ref_mem[12'h10F];
    h_stop = 1'b1; cpu_addr = 12'h10F; cpu_we = 1'b1; cpu_din = d;
    step();
    h_stop = 1'b0; cpu_we = 1'b0;
    rc_exp++;
    ref_mem[12'h10F] = d;
    chk("stop_cpu_rst_n", cpu_rst_n, 0);
    chk("stop_h_ready", h_ready, 1);
    chk("stop_run_cycles", run_cycles, rc_exp);
    chk("stop_cpu_dout", cpu_dout, exp);
    cpu_addr = 12'h004; cpu_we = 1'b1; cpu_din = 32'hDEAD_BEEF;
    step();
    cpu_we = 1'b0;
    chk("load_run_cycles_hold", run_cycles, rc_exp);
    chk("load_cpu_dout_hold", cpu_dout, exp);
    hread(12'h10F);
    hread(12'h004);

    // Mano program: LDA 4, ADD 5, STA 6, BUN 3
    op1 = 32'($urandom_range(0, 16'hFFFF));
    op2 = 32'($urandom_range(0, 16'hFFFF));
    hwrite(12'h000, 32'h0000_2004);
    hwrite(12'h001, 32'h0000_1005);
    hwrite(12'h002, 32'h0000_3006);
    hwrite(12'h003, 32'h0000_4003);
    hwrite(12'h004, op1);
    hwrite(12'h005, op2);
    hwrite(12'h006, 32'h0);

    // Start and stop together in LOAD, plus a host read on that edge
    h_start = 1'b1; h_stop = 1'b1; h_valid = 1'b1; h_we = 1'b0; h_addr = 12'h005;
    step();
    h_start = 1'b0; h_stop = 1'b0; h_valid = 1'b0;
    rc_exp = 0;
    chk("start2_rvalid", h_rvalid, 1);
    chk("start2_rdata", h_rdata, op2);
    chk("start2_cpu_rst_n", cpu_rst_n, 1);
    chk("start2_run_cycles", run_cycles, 0);
    step();
    rc_exp++;
    chk("start2_rvalid_drop", h_rvalid, 0);

    pc = '0; ac = '0;
    while (rc_exp < 100) begin
      cpu_addr = pc;
      step(); step(); rc_exp += 2;
      ir = cpu_dout;
      pc = pc + AW'(1);
      adr = ir[AW-1:0];
      case (ir[15:12])
        4'h2: begin cpu_addr = adr; step(); step(); rc_exp += 2; ac = cpu_dout; end
        4'h1: begin cpu_addr = adr; step(); step(); rc_exp += 2; ac = ac + cpu_dout; end
        4'h3: begin
          cpu_addr = adr; cpu_din = ac; cpu_we = 1'b1;
          step(); cpu_we = 1'b0; rc_exp += 1;
        end
        4'h4: pc = adr;
        default: pc = pc;
      endcase
    end
    chk("prog_run_cycles", run_cycles, rc_exp);
    h_stop = 1'b1; h_start = 1'b1;
    step();
    h_stop = 1'b0; h_start = 1'b0;
    rc_exp++;
    chk("prog_stop_cpu_rst_n", cpu_rst_n, 0);
    chk("prog_stop_run_cycles", run_cycles, rc_exp);
    ref_mem[12'h006] = op1 + op2;
    hread(12'h006);

    // Reset asserted in RUN clears outputs immediately
    h_start = 1'b1;
    step();
    h_start = 1'b0;
    rc_exp = 0;
    cpu_cycle(12'h010, 1'b0, '0);
    reset_n = 1'b0;
    #1;
    chk("rstrun_cpu_dout", cpu_dout, 0);
    chk("rstrun_cpu_rst_n", cpu_rst_n, 0);
    chk("rstrun_run_cycles", run_cycles, 0);
    chk("rstrun_h_ready", h_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();
    chk("rstrun_h_ready_after", h_ready, 1);

    // Reset drops a pending read pulse
    h_valid = 1'b1; h_we = 1'b0; h_addr = 12'h010;
    step();
    h_valid = 1'b0;
    chk("pend_rvalid", h_rvalid, 1);
    reset_n = 1'b0;
    #1;
    chk("pend_rvalid_drop", h_rvalid, 0);
    chk("pend_rdata_clear", h_rdata, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();
    hread(12'h010);
    hread(12'h006);
    hread(12'h004);
    hread(12'h10F);

    // Small memory: out-of-range writes dropped, reads return zero, no wrap
    chk("small_h_ready", s_h_ready, 1);
    s_h_valid = 1'b1; s_h_we = 1'b1;
    s_h_addr = 12'h000; s_h_wdata = 32'h1111_2222; step();
    s_h_addr = 12'h00F; s_h_wdata = 32'h3333_4444; step();
    s_h_addr = 12'h020; s_h_wdata = 32'h5555_6666; step();
    s_h_we = 1'b0;
    s_h_addr = 12'h020; step();
    chk("small_oor_rvalid", s_h_rvalid, 1);
    chk("small_oor_rdata", s_h_rdata, 0);
    s_h_addr = 12'h00F; step();
    chk("small_top_rvalid", s_h_rvalid, 1);
    chk("small_top_rdata", s_h_rdata, 32'h3333_4444);
    s_h_addr = 12'h000; step();
    chk("small_nowrap_rdata", s_h_rdata, 32'h1111_2222);
    s_h_valid = 1'b0; step();
    chk("small_rvalid_drop", s_h_rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
